axis_bram_recorder: RTL and testbench
=====================================

AXIS_BRAM_RECORDER -- requirements
Module: axis_bram_recorder

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, stream data width, and it SHALL equal BRAM_DATA_WIDTH.
REQ-002 The block SHALL have parameter BRAM_DATA_WIDTH, default 32, BRAM word width, and it SHALL be a multiple of 8.
REQ-003 The block SHALL have parameter BRAM_ADDR_WIDTH, default 10, BRAM address width (AW).
REQ-004 The block SHALL have port aclk, input, 1, the single clock.
REQ-005 The block SHALL have port areset, input, 1, a synchronous, active-high reset.
REQ-006 The block SHALL have port cfg_start, input, 1, a start/restart request sampled each cycle.
REQ-007 The block SHALL have port cfg_mode, input, 1, where 0 = one-shot and 1 = continuous re-arm.
REQ-008 The block SHALL have port cfg_last, input, AW, the ring wrap address (last valid address).
REQ-009 The block SHALL have port cfg_pre, input, AW, the number of pre-trigger beats written before arming.
REQ-010 The block SHALL have port cfg_post, input, AW, the number of beats written after the trigger beat.
REQ-011 The block SHALL have port trg_in, input, 1, the trigger qualifier for the current beat.
REQ-012 The block SHALL have port sts_addr, output, AW, the next write address.
REQ-013 The block SHALL have port sts_trg_addr, output, AW, the address of the last trigger beat.
REQ-014 The block SHALL have port sts_state, output, 3, the FSM state encoding.
REQ-015 The block SHALL have port sts_done, output, 1, high in DONE.
REQ-016 The block SHALL have ports s_axis_tdata (input, AXIS_TDATA_WIDTH), s_axis_tvalid (input, 1) and s_axis_tready (output, 1).
REQ-017 The block SHALL have ports b_bram_clk, b_bram_rst, b_bram_en (outputs, 1), b_bram_we (output, BRAM_DATA_WIDTH/8), b_bram_addr (output, AW) and b_bram_wdata (output, BRAM_DATA_WIDTH).

Function
REQ-018 s_axis_tready SHALL be constant 1; beats arriving in IDLE or DONE are discarded.
REQ-019 b_bram_clk SHALL equal aclk, and b_bram_rst SHALL equal areset.
REQ-020 A write SHALL occur when tvalid is high in PRE, ARMED or POST: en=1, all we bits = 1, addr=sts_addr, wdata=tdata, same cycle (zero latency); otherwise en=0 and we=0.
REQ-021 After every write, the address SHALL update as addr==cfg_last_r ? 0 : addr+1; if addr>cfg_last_r, it SHALL wrap modulo 2^AW.
REQ-022 cfg_mode, cfg_last, cfg_pre and cfg_post SHALL be registered (the *_r copies) on an accepted cfg_start and ignored otherwise.
REQ-023 State encodings SHALL be: IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
REQ-024 cfg_start=1 in any state SHALL: set addr=0, clear counters, and go to PRE if cfg_pre≠0, else to ARMED; it SHALL take priority over all other transitions.
REQ-025 PRE SHALL count written beats and go to ARMED on the cycle the cfg_pre_r-th beat is written.
REQ-026 ARMED SHALL write continuously; a beat with tvalid=1 and trg_in=1 SHALL be the trigger beat: it is written, its address goes to sts_trg_addr, and the FSM goes to POST (or to the end action if cfg_post_r=0).
REQ-027 trg_in SHALL be ignored when tvalid=0 and outside ARMED.
REQ-028 POST SHALL count written beats and take the end action on the cycle the cfg_post_r-th beat is written.
REQ-029 The end action SHALL be: go to DONE if cfg_mode_r=0; if cfg_mode_r=1, go to PRE (or to ARMED if cfg_pre_r=0), with counters cleared and addr continuing (not reset).
REQ-030 DONE SHALL perform no writes, hold sts_addr and sts_trg_addr, and leave only on cfg_start or areset.
REQ-031 Pre/post counters SHALL be AW bits wide.

Reset
REQ-032 On areset=1 at a clock edge, the block SHALL enter IDLE and set sts_addr=0, sts_trg_addr=0, sts_done=0 and all *_r copies = 0.
REQ-033 While areset=1, b_bram_en=0, b_bram_we=0 and b_bram_rst=1.
REQ-034 Reset asserted mid-capture SHALL abort with no further writes, and areset SHALL dominate cfg_start.

Verification
REQ-035 Reset then idle: tvalid=1 for 10 cycles -> no writes, sts_state=0, sts_addr=0.
REQ-036 One-shot: last=15, pre=4, post=3, continuous tvalid, trg_in on the 7th beat -> state sequence PRE→ARMED→POST→DONE, writes at 0..9, sts_trg_addr=6, sts_addr=10, sts_done=1.
REQ-037 Wrap: last=7, pre=2, post=5, trigger on the 12th beat -> sts_trg_addr=3, addresses wrap 7→0, final sts_addr=1.
REQ-038 Gapped tvalid with trg_in held high during a tvalid=0 cycle -> no trigger; the trigger fires on the next valid beat.
REQ-039 Continuous mode: pre=0, post=1 -> two triggers produce two POST passes, addr never resets, sts_done stays 0.
REQ-040 cfg_start during POST, and areset concurrent with cfg_start -> restart at addr 0 in the first case; IDLE in the second.

Source files
------------

// File: rtl/axis_bram_recorder.sv
// axis_bram_recorder
//   Records an AXI-Stream into a BRAM ring buffer with pre-trigger history,
//   a trigger beat and a post-trigger tail. It runs as a one-shot capture or
//   re-arms continuously. BRAM writes are combinational from the current beat,
//   so they have zero latency.
// Ports
//   aclk, areset          : clock, synchronous active-high reset
//   cfg_start             : start/restart; latches cfg_mode/last/pre/post
//   cfg_mode              : 0 one-shot, 1 continuous re-arm
//   cfg_last              : last ring address (wrap point)
//   cfg_pre / cfg_post    : beats written before arming / after the trigger
//   trg_in                : trigger qualifier for the current beat
//   sts_addr/sts_trg_addr : next write address / address of the last trigger
//   sts_state, sts_done   : FSM state encoding, high while in DONE
//   s_axis_*              : input stream (always ready)
//   b_bram_*              : BRAM write port
module axis_bram_recorder #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         cfg_start,
    input  logic                         cfg_mode,
    input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_last,
    input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_pre,
    input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_post,
    input  logic                         trg_in,
    output logic [BRAM_ADDR_WIDTH-1:0]   sts_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]   sts_trg_addr,
    output logic [2:0]                   sts_state,
    output logic                         sts_done,
    input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic                         b_bram_clk,
    output logic                         b_bram_rst,
    output logic                         b_bram_en,
    output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]   b_bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   b_bram_wdata
);
    localparam int AW = BRAM_ADDR_WIDTH;

    if (AXIS_TDATA_WIDTH != BRAM_DATA_WIDTH) begin : g_bad_width
        $error("AXIS_TDATA_WIDTH must equal BRAM_DATA_WIDTH");
    end
    if (BRAM_DATA_WIDTH % 8 != 0) begin : g_bad_bytes
        $error("BRAM_DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q, trg_q, cnt;
    logic [AW-1:0] last_r, pre_r, post_r;
    logic          mode_r, done_q;

    logic          capturing, wr_en;
    logic [AW-1:0] cnt_inc;
    state_t        end_state;

    assign capturing = (state == PRE) || (state == ARMED) || (state == POST);
    // Reset gates the write strobe combinationally so nothing lands in BRAM
    // during the reset cycle, even mid-capture.
    assign wr_en     = s_axis_tvalid && capturing && !areset;
    assign cnt_inc   = cnt + 1'b1;
    // Where a completed post-trigger tail goes: stop, or re-arm in place.
    assign end_state = !mode_r ? DONE : ((pre_r != '0) ? PRE : ARMED);

    assign s_axis_tready = 1'b1;
    assign b_bram_clk    = aclk;
    assign b_bram_rst    = areset;
    assign b_bram_en     = wr_en;
    assign b_bram_we     = {(BRAM_DATA_WIDTH/8){wr_en}};
    assign b_bram_addr   = addr_q;
    assign b_bram_wdata  = s_axis_tdata;

    assign sts_addr      = addr_q;
    assign sts_trg_addr  = trg_q;
    assign sts_state     = state;
    assign sts_done      = done_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            addr_q <= '0;
            trg_q  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            mode_r <= 1'b0;
            last_r <= '0;
            pre_r  <= '0;
            post_r <= '0;
        end else if (cfg_start) begin
            mode_r <= cfg_mode;
            last_r <= cfg_last;
            pre_r  <= cfg_pre;
            post_r <= cfg_post;
            addr_q <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            state  <= (cfg_pre != '0) ? PRE : ARMED;
        end else if (wr_en) begin
            // Equality wrap; an address already past last_r rolls at 2^AW.
            addr_q <= (addr_q == last_r) ? '0 : addr_q + 1'b1;
            case (state)
                PRE: begin
                    if (cnt_inc == pre_r) begin
                        state <= ARMED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ARMED: begin
                    if (trg_in) begin
                        trg_q <= addr_q;
                        cnt   <= '0;
                        if (post_r == '0) begin
                            state  <= end_state;
                            done_q <= !mode_r;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    if (cnt_inc == post_r) begin
                        state  <= end_state;
                        cnt    <= '0;
                        done_q <= !mode_r;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_bram_recorder.sv
module tb_axis_bram_recorder;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1, cfg_start = 1'b0, cfg_mode = 1'b0, trg_in = 1'b0;
  logic [AW-1:0] cfg_last = '0, cfg_pre = '0, cfg_post = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [AW-1:0] sts_addr, sts_trg_addr, b_bram_addr;
  logic [2:0]    sts_state;
  logic          sts_done, s_axis_tready, b_bram_clk, b_bram_rst, b_bram_en;
  logic [DW/8-1:0] b_bram_we;
  logic [DW-1:0] b_bram_wdata;

  int errors = 0;
  int checks = 0;

  axis_bram_recorder #(.AXIS_TDATA_WIDTH(DW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_last(cfg_last), .cfg_pre(cfg_pre), .cfg_post(cfg_post), .trg_in(trg_in),
    .sts_addr(sts_addr), .sts_trg_addr(sts_trg_addr), .sts_state(sts_state), .sts_done(sts_done),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .b_bram_clk(b_bram_clk), .b_bram_rst(b_bram_rst), .b_bram_en(b_bram_en), .b_bram_we(b_bram_we),
    .b_bram_addr(b_bram_addr), .b_bram_wdata(b_bram_wdata)
  );

  always #5 aclk = ~aclk;

  // Reference model: a phase name, a beats-in-phase tally and the ring pointer.
  // Phases: 0 idle, 1 collecting history, 2 waiting for trigger, 3 tail, 4 finished.
  int m_phase = 0, m_ptr = 0, m_trg = 0, m_beats = 0;
  int k_mode = 0, k_last = 0, k_pre = 0, k_post = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void finish_tail();
    m_beats = 0;
    if (k_mode == 0) m_phase = 4;
    else m_phase = (k_pre > 0) ? 1 : 2;
  endfunction

  // One clock: drive inputs, check the write port mid-cycle, advance the model,
  // then check the status registers just after the edge.
  task automatic step(input bit rst, input bit start, input bit valid, input bit trg);
    bit wr;
    areset = rst; cfg_start = start; s_axis_tvalid = valid; trg_in = trg;
    s_axis_tdata = $urandom;
    @(negedge aclk);
    wr = !rst && valid && (m_phase >= 1 && m_phase <= 3);
    chk("tready", s_axis_tready, 1);
    chk("bram_rst", b_bram_rst, rst);
    chk("bram_en", b_bram_en, wr);
    chk("bram_we", b_bram_we, wr ? 4'hF : 4'h0);
    if (wr) begin
      chk("bram_addr", b_bram_addr, m_ptr);
      chk("bram_wdata", b_bram_wdata, s_axis_tdata);
    end
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_trg = 0; m_beats = 0;
      k_mode = 0; k_last = 0; k_pre = 0; k_post = 0;
    end else if (start) begin
      k_mode = cfg_mode; k_last = cfg_last; k_pre = cfg_pre; k_post = cfg_post;
      m_ptr = 0; m_beats = 0;
      m_phase = (k_pre > 0) ? 1 : 2;
    end else if (wr) begin
      int here = m_ptr;
      m_ptr = (m_ptr == k_last) ? 0 : (m_ptr + 1) % (1 << AW);
      if (m_phase == 1) begin
        m_beats++;
        if (m_beats == k_pre) begin m_phase = 2; m_beats = 0; end
      end else if (m_phase == 2) begin
        if (trg) begin
          m_trg = here; m_beats = 0;
          if (k_post == 0) finish_tail(); else m_phase = 3;
        end
      end else begin
        m_beats++;
        if (m_beats == k_post) finish_tail();
      end
    end
    @(posedge aclk);
    #1;
    chk("sts_state", sts_state, m_phase);
    chk("sts_addr", sts_addr, m_ptr);
    chk("sts_trg_addr", sts_trg_addr, m_trg);
    chk("sts_done", sts_done, m_phase == 4);
  endtask

  task automatic cfg(input bit mode, input int last, input int pre, input int post);
    cfg_mode = mode; cfg_last = AW'(last); cfg_pre = AW'(pre); cfg_post = AW'(post);
  endtask

  initial begin
    // Reset then idle stream: nothing is written
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("rst_state", sts_state, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    chk("idle_state", sts_state, 0);
    chk("idle_addr", sts_addr, 0);

    // One-shot, trigger on the 7th beat
    cfg(0, 15, 4, 3);
    step(0, 1, 0, 0);
    chk("os_pre", sts_state, 1);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, i == 7);
      if (i == 4) chk("os_armed", sts_state, 2);
      if (i == 7) chk("os_post", sts_state, 3);
    end
    chk("os_trg", sts_trg_addr, 6);
    chk("os_addr", sts_addr, 10);
    chk("os_done", sts_done, 1);
    chk("os_state", sts_state, 4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    chk("os_hold", sts_addr, 10);

    // Ring wrap, trigger on the 12th beat
    cfg(0, 7, 2, 5);
    step(0, 1, 0, 0);
    for (int i = 1; i <= 17; i++) step(0, 0, 1, i == 12);
    chk("wr_trg", sts_trg_addr, 3);
    chk("wr_addr", sts_addr, 1);
    chk("wr_done", sts_done, 1);

    // Trigger held during a gap is not taken until the next valid beat
    cfg(0, 31, 1, 2);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("gap_no_trg", sts_state, 2);
    step(0, 0, 1, 1);
    chk("gap_trg", sts_trg_addr, 2);
    chk("gap_post", sts_state, 3);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("gap_done", sts_state, 4);

    // Continuous re-arm, no pre-history, one-beat tail
    cfg(1, 20, 0, 1);
    step(0, 1, 0, 0);
    chk("cm_armed", sts_state, 2);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("cm_post1", sts_state, 3);
    step(0, 0, 1, 0);
    chk("cm_rearm", sts_state, 2);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("cm_trg2", sts_trg_addr, 3);
    chk("cm_addr", sts_addr, 5);
    chk("cm_done", sts_done, 0);

    // Restart from the tail, then reset beating a concurrent start
    cfg(0, 50, 0, 10);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("rs_post", sts_state, 3);
    step(0, 1, 1, 0);
    chk("rs_addr", sts_addr, 0);
    chk("rs_state", sts_state, 2);
    step(0, 0, 1, 0);
    step(1, 1, 1, 1);
    chk("rs_idle", sts_state, 0);
    chk("rs_idle_addr", sts_addr, 0);

    // Randomized traffic with configuration churn
    for (int i = 0; i < 1500; i++) begin
      cfg($urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 5));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
